// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage controller: load-use stalls, taken-branch redirect/flush,
// halt/drain/resume sequencing and saturating stall/flush counters.
module fetch_hazard_ctrl #(
  parameter int unsigned PC_BITS      = 10,
  parameter int unsigned CNT_BITS     = 16,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_ex_mem_read,
  input  logic [4:0]          id_ex_rd,
  input  logic [4:0]          if_id_rn,
  input  logic [4:0]          if_id_rm,
  input  logic                if_id_uses_rm,
  input  logic                branch_taken,
  input  logic [PC_BITS-1:0]  branch_target,
  input  logic                halt_req,
  input  logic                resume,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                pc_src,
  output logic [PC_BITS-1:0]  pc_target,
  output logic                if_id_flush,
  output logic                id_ex_bubble,
  output logic [1:0]          state,
  output logic [CNT_BITS-1:0] stall_count,
  output logic [CNT_BITS-1:0] flush_count
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0]  DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t               state_q;
  logic [DRAIN_W-1:0]   drain_q;
  logic                 load_use;
  logic                 stall_inc;
  logic                 flush_inc;

  assign pc_target = branch_target;
  assign state     = state_q;

  // XZR (X31) is never a real producer, so it cannot create a hazard
  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd31) &&
                    ((id_ex_rd == if_id_rn) ||
                     (if_id_uses_rm && (id_ex_rd == if_id_rm)));

  // Fetch controls and counter events, decoded from state and current inputs
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    pc_src       = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            pc_src       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
          end else if (load_use) begin
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
          end
        end
        ST_DRAIN: begin
          id_ex_bubble = 1'b1;
          if (branch_taken) begin
            pc_write    = 1'b1;
            pc_src      = 1'b1;
            if_id_flush = 1'b1;
            flush_inc   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, drain countdown and saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && (stall_count != CNT_MAX)) stall_count <= stall_count + 1'b1;
      if (flush_inc && (flush_count != CNT_MAX)) flush_count <= flush_count + 1'b1;
      case (state_q)
        ST_RUN: begin
          if (halt_req) begin
            state_q <= ST_DRAIN;
            drain_q <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) state_q <= ST_HALTED;
          else               drain_q <= drain_q - 1'b1;
        end
        ST_HALTED: begin
          if (resume) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed bench for fetch_hazard_ctrl: hazards, redirects, halt/drain/resume,
// counter saturation and asynchronous reset.
module tb_fetch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rd;
  logic [4:0] if_id_rn;
  logic [4:0] if_id_rm;
  logic       if_id_uses_rm;
  logic       branch_taken;
  logic [9:0] branch_target;
  logic       halt_req;
  logic       resume;
  logic       pc_write;
  logic       if_id_write;
  logic       pc_src;
  logic [9:0] pc_target;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic [1:0] state;
  logic [3:0] stall_count;
  logic [3:0] flush_count;

  int checks = 0;
  int errors = 0;

  fetch_hazard_ctrl #(.PC_BITS(10), .CNT_BITS(4), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rn(if_id_rn), .if_id_rm(if_id_rm), .if_id_uses_rm(if_id_uses_rm),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_req(halt_req), .resume(resume),
    .pc_write(pc_write), .if_id_write(if_id_write), .pc_src(pc_src),
    .pc_target(pc_target), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_ex_mem_read = 1'b0; id_ex_rd = 5'd0; if_id_rn = 5'd1; if_id_rm = 5'd2;
    if_id_uses_rm = 1'b0; branch_taken = 1'b0; branch_target = 10'd0;
    halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic set_load_use();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rn = 5'd5;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #3;
    chk("reset_pc_write", 32'(pc_write), 32'd0);
    chk("reset_if_id_write", 32'(if_id_write), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_stall", 32'(stall_count), 32'd0);
    #9 reset = 1'b0;
    tick();
    chk("run_pc_write", 32'(pc_write), 32'd1);

    // load-use stall for one cycle
    set_load_use();
    #1;
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_if_id_write", 32'(if_id_write), 32'd0);
    chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
    tick();
    idle();
    #1;
    chk("lu_stall_count", 32'(stall_count), 32'd1);
    chk("lu_release", 32'(pc_write), 32'd1);

    // XZR and unused Rm never hazard
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd31; if_id_rn = 5'd31;
    #1;
    chk("xzr_pc_write", 32'(pc_write), 32'd1);
    chk("xzr_bubble", 32'(id_ex_bubble), 32'd0);
    id_ex_rd = 5'd7; if_id_rn = 5'd0; if_id_rm = 5'd7; if_id_uses_rm = 1'b0;
    #1;
    chk("rm_unused_pc_write", 32'(pc_write), 32'd1);
    if_id_uses_rm = 1'b1;
    #1;
    chk("rm_used_pc_write", 32'(pc_write), 32'd0);
    idle();
    tick();
    chk("no_stall_count", 32'(stall_count), 32'd1);

    // taken branch squashes coincident load-use
    set_load_use();
    branch_taken = 1'b1; branch_target = 10'h040;
    #1;
    chk("br_pc_src", 32'(pc_src), 32'd1);
    chk("br_pc_target", 32'(pc_target), 32'h040);
    chk("br_flush", 32'(if_id_flush), 32'd1);
    chk("br_pc_write", 32'(pc_write), 32'd1);
    chk("br_bubble", 32'(id_ex_bubble), 32'd1);
    tick();
    idle();
    #1;
    chk("br_flush_count", 32'(flush_count), 32'd1);
    chk("br_stall_count", 32'(stall_count), 32'd1);

    // halt pulse: three DRAIN cycles then HALTED
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    #1;
    chk("drain1_state", 32'(state), 32'd1);
    chk("drain_pc_write", 32'(pc_write), 32'd0);
    chk("drain_bubble", 32'(id_ex_bubble), 32'd1);
    set_load_use();
    branch_taken = 1'b1; branch_target = 10'h100;
    #1;
    chk("drain_br_pc_write", 32'(pc_write), 32'd1);
    chk("drain_br_pc_src", 32'(pc_src), 32'd1);
    chk("drain_br_flush", 32'(if_id_flush), 32'd1);
    chk("drain_br_if_id_write", 32'(if_id_write), 32'd0);
    tick();
    idle();
    #1;
    chk("drain2_state", 32'(state), 32'd1);
    chk("drain_flush_count", 32'(flush_count), 32'd2);
    chk("drain_stall_count", 32'(stall_count), 32'd1);
    tick();
    chk("drain3_state", 32'(state), 32'd1);
    tick();
    chk("halted_state", 32'(state), 32'd2);
    chk("halted_bubble", 32'(id_ex_bubble), 32'd0);
    branch_taken = 1'b1; halt_req = 1'b1;
    #1;
    chk("halted_br_pc_write", 32'(pc_write), 32'd0);
    chk("halted_br_flush", 32'(if_id_flush), 32'd0);
    tick();
    chk("halted_hold_state", 32'(state), 32'd2);
    chk("halted_flush_count", 32'(flush_count), 32'd2);
    branch_taken = 1'b0;
    resume = 1'b1;
    tick();
    idle();
    #1;
    chk("resume_state", 32'(state), 32'd0);
    chk("resume_pc_write", 32'(pc_write), 32'd1);

    // stall counter saturates at 15
    set_load_use();
    repeat (20) tick();
    chk("sat_stall_count", 32'(stall_count), 32'd15);
    tick();
    chk("sat_hold", 32'(stall_count), 32'd15);
    idle();

    // asynchronous reset mid-DRAIN
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("pre_reset_state", 32'(state), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_stall", 32'(stall_count), 32'd0);
    chk("async_flush", 32'(flush_count), 32'd0);
    chk("async_bubble", 32'(id_ex_bubble), 32'd0);
    #3 reset = 1'b0;
    tick();
    chk("post_reset_state", 32'(state), 32'd0);
    chk("post_reset_pc_write", 32'(pc_write), 32'd1);
    tick();
    chk("post_reset_run", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
